// File: rtl/logic_tree_feeder.sv
// Two-entry operand FIFO feeding an 8-input logic tree. Vectors come from an
// upstream stream or from an internal 0..SWEEP_LAST sweep generator.
module logic_tree_feeder #(
  parameter int unsigned SWEEP_LAST = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       sweep_start,
  output logic       sweep_busy,
  output logic       sweep_done,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       h,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] count
);

  typedef enum logic [1:0] {StIdle, StSweep, StFinish} state_t;

  state_t      state_q, state_d;
  logic [7:0]  head_q, head_d;
  logic [7:0]  tail_q, tail_d;
  logic [1:0]  count_q, count_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        pop;
  logic        stream_push;
  logic        sweep_push;
  logic        push;
  logic [7:0]  push_data;

  assign pop         = (count_q != 2'd0) & out_ready;
  // Gated by rst_n so the upstream sees no acceptance while reset is held.
  assign in_ready    = rst_n & (state_q == StIdle) & (count_q < 2'd2) & ~sweep_start;
  assign stream_push = in_valid & in_ready;
  // The generator may refill a full FIFO in the same cycle an entry leaves.
  assign sweep_push  = (state_q == StSweep) & ((count_q < 2'd2) | pop);
  assign push        = stream_push | sweep_push;
  assign push_data   = sweep_push ? cnt_q[7:0] : in_data;

  // FIFO next state: head is always the presented vector, cleared when empty.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = push_data;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = push_data;
        end else if (push) begin
          tail_d  = push_data;
          count_d = 2'd2;
        end else if (pop) begin
          head_d  = 8'h00;
          count_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d = tail_q;
          if (push) begin
            tail_d = push_data;
          end else begin
            count_d = 2'd1;
          end
        end
      end
    endcase
  end

  // Sweep controller next state and registered status flags.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (sweep_start) begin
          state_d = StSweep;
          cnt_d   = 9'd0;
        end
      end
      StSweep: begin
        if (sweep_push) begin
          cnt_d = cnt_q + 9'd1;
          if (cnt_q == 9'(SWEEP_LAST)) state_d = StFinish;
        end
      end
      StFinish: begin
        if (count_q == 2'd0) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      head_q  <= 8'h00;
      tail_q  <= 8'h00;
      count_q <= 2'd0;
      cnt_q   <= 9'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign {h, g, f, e, d, c, b, a} = head_q;
  assign out_valid  = (count_q != 2'd0);
  assign count      = count_q;
  assign sweep_busy = busy_q;
  assign sweep_done = done_q;

endmodule

// File: tb/tb_logic_tree_feeder.sv
// Directed bench for logic_tree_feeder: stream, backpressure, sweep, reset.
module tb_logic_tree_feeder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       sweep_start;
  logic       sweep_busy;
  logic       sweep_done;
  logic       a, b, c, d, e, f, g, h;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] count;

  int checks = 0;
  int errors = 0;

  logic [7:0] vec;
  assign vec = {h, g, f, e, d, c, b, a};

  always #5 clk = ~clk;

  logic_tree_feeder #(.SWEEP_LAST(255)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done),
    .a           (a),
    .b           (b),
    .c           (c),
    .d           (d),
    .e           (e),
    .f           (f),
    .g           (g),
    .h           (h),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .count       (count)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs a full 0..255 sweep, optionally behind a pending stream entry and with
  // random downstream stalls, checking order, busy, in_ready and the done pulse.
  task automatic do_sweep(input bit stall, input bit pend);
    int idx;
    int total;
    int dones;
    int cyc;
    logic [7:0] expv;
    total = 256 + (pend ? 1 : 0);
    idx   = 0;
    dones = 0;
    if (pend) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h5A;
      tick();
      in_valid  = 1'b0;
      check_eq("pend_count", count, 2'd1);
    end
    sweep_start = 1'b1;
    #1;
    check_eq("ready_on_start", in_ready, 1'b0);
    tick();
    sweep_start = 1'b0;
    in_valid    = 1'b1;
    in_data     = 8'hEE;
    for (cyc = 0; cyc < 3000; cyc++) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (out_valid && out_ready) begin
        expv = (pend && idx == 0) ? 8'h5A : 8'(idx - (pend ? 1 : 0));
        if (vec !== expv) check_eq("sweep_order", vec, expv);
        idx++;
      end
      if (sweep_done) begin
        dones++;
        check_eq("done_busy_low", sweep_busy, 1'b0);
        check_eq("done_after_all", idx, total);
        break;
      end
      if (sweep_busy !== 1'b1) check_eq("busy_during", sweep_busy, 1'b1);
      if (in_ready !== 1'b0) check_eq("ready_while_busy", in_ready, 1'b0);
      tick();
    end
    check_eq("sweep_done_seen", dones, 1);
    in_valid = 1'b0;
    tick();
    check_eq("done_single_pulse", sweep_done, 1'b0);
    check_eq("idle_after_sweep", in_ready, 1'b1);
  endtask

  initial begin
    int n;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    sweep_start = 1'b0;
    out_ready   = 1'b0;
    tick();
    tick();
    check_eq("rst_count", count, 2'd0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_vec", vec, 8'h00);
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_busy", sweep_busy, 1'b0);
    check_eq("rst_done", sweep_done, 1'b0);

    rst_n = 1'b1;
    #1;
    check_eq("rel_in_ready", in_ready, 1'b1);
    check_eq("rel_out_valid", out_valid, 1'b0);

    // Single stream vector, presented the cycle after its push.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    tick();
    in_valid = 1'b0;
    check_eq("a5_valid", out_valid, 1'b1);
    check_eq("a5_vec", vec, 8'hA5);
    check_eq("a5_a", a, 1'b1);
    check_eq("a5_b", b, 1'b0);
    check_eq("a5_h", h, 1'b1);
    check_eq("a5_count", count, 2'd1);
    tick();
    check_eq("a5_drain_count", count, 2'd0);
    check_eq("a5_drain_vec", vec, 8'h00);

    // Backpressure: fill to two, third offer refused, then drain in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    tick();
    in_data = 8'h22;
    tick();
    in_data = 8'h33;
    check_eq("full_count", count, 2'd2);
    check_eq("full_in_ready", in_ready, 1'b0);
    tick();
    in_valid = 1'b0;
    check_eq("full_hold_count", count, 2'd2);
    check_eq("full_hold_vec", vec, 8'h11);
    out_ready = 1'b1;
    tick();
    check_eq("drain_second", vec, 8'h22);
    check_eq("drain_count", count, 2'd1);
    tick();
    check_eq("drain_empty", count, 2'd0);
    check_eq("drain_no_33", out_valid, 1'b0);

    // Sustained push and pop.
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = 8'(8'h40 + i);
      tick();
      check_eq("stream_vec", vec, 8'(8'h40 + i));
      check_eq("stream_count", count, 2'd1);
    end
    in_valid = 1'b0;
    tick();
    check_eq("stream_end", count, 2'd0);

    do_sweep(1'b0, 1'b0);
    do_sweep(1'b1, 1'b1);

    // Reset in the middle of a sweep.
    out_ready   = 1'b1;
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    for (n = 0; n < 500; n++) begin
      if (out_valid && vec == 8'd100) break;
      tick();
    end
    check_eq("reach_100", (n < 500), 1'b1);
    rst_n = 1'b0;
    tick();
    check_eq("mid_rst_count", count, 2'd0);
    check_eq("mid_rst_valid", out_valid, 1'b0);
    check_eq("mid_rst_busy", sweep_busy, 1'b0);
    check_eq("mid_rst_done", sweep_done, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (sweep_done !== 1'b0) check_eq("post_rst_done", sweep_done, 1'b0);
    end
    check_eq("post_rst_ready", in_ready, 1'b1);
    check_eq("post_rst_empty", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
